// File: rtl/sum_sequencer.sv
// Control sequencer for a register-file datapath computing Sum = 1+2+...+n (mod 256).
// All control outputs are registered copies of the decode of the next state.
module sum_sequencer #(
  parameter logic [1:0] ACC_REG = 2'd0,
  parameter logic [1:0] CNT_REG = 2'd1
) (
  input  logic       clk,
  input  logic       restart,
  input  logic       start,
  input  logic       zflag,
  output logic       IE,
  output logic       WE,
  output logic [1:0] WA,
  output logic       RAE,
  output logic [1:0] RAA,
  output logic       RBE,
  output logic [1:0] RBA,
  output logic [2:0] ALU,
  output logic [1:0] SH,
  output logic       OE,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOADN = 3'd1,
    CLR   = 3'd2,
    CHK   = 3'd3,
    ADD   = 3'd4,
    DEC   = 3'd5,
    DONE  = 3'd6
  } state_t;

  typedef struct packed {
    logic       ie;
    logic       we;
    logic [1:0] wa;
    logic       rae;
    logic [1:0] raa;
    logic       rbe;
    logic [1:0] rba;
    logic [2:0] alu;
    logic [1:0] sh;
    logic       oe;
    logic       busy;
    logic       done;
  } ctrl_t;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;
  localparam logic [2:0] ALU_DEC  = 3'b111;

  state_t state_q, state_d;
  ctrl_t  ctrl_q;

  // Control word for each state; any field not set stays 0, SH is always pass.
  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      LOADN: begin
        c.ie = 1'b1; c.we = 1'b1; c.wa = CNT_REG; c.busy = 1'b1;
      end
      CLR: begin
        c.we = 1'b1; c.wa = ACC_REG;
        c.rae = 1'b1; c.raa = CNT_REG; c.rbe = 1'b1; c.rba = CNT_REG;
        c.alu = ALU_SUB; c.busy = 1'b1;
      end
      CHK: begin
        c.rae = 1'b1; c.raa = CNT_REG; c.alu = ALU_PASS; c.busy = 1'b1;
      end
      ADD: begin
        c.we = 1'b1; c.wa = ACC_REG;
        c.rae = 1'b1; c.raa = ACC_REG; c.rbe = 1'b1; c.rba = CNT_REG;
        c.alu = ALU_ADD; c.busy = 1'b1;
      end
      DEC: begin
        c.we = 1'b1; c.wa = CNT_REG;
        c.rae = 1'b1; c.raa = CNT_REG; c.alu = ALU_DEC; c.busy = 1'b1;
      end
      DONE: begin
        c.rae = 1'b1; c.raa = ACC_REG; c.alu = ALU_PASS; c.oe = 1'b1; c.done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = start ? LOADN : IDLE;
      LOADN:   state_d = CLR;
      CLR:     state_d = CHK;
      CHK:     state_d = zflag ? DONE : ADD;
      ADD:     state_d = DEC;
      DEC:     state_d = CHK;
      DONE:    state_d = start ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_for(state_d);
    end
  end

  assign IE   = ctrl_q.ie;
  assign WE   = ctrl_q.we;
  assign WA   = ctrl_q.wa;
  assign RAE  = ctrl_q.rae;
  assign RAA  = ctrl_q.raa;
  assign RBE  = ctrl_q.rbe;
  assign RBA  = ctrl_q.rba;
  assign ALU  = ctrl_q.alu;
  assign SH   = ctrl_q.sh;
  assign OE   = ctrl_q.oe;
  assign busy = ctrl_q.busy;
  assign done = ctrl_q.done;

endmodule

// File: doc/sum_sequencer.md
SUM_SEQUENCER -- requirements
Module: sum_sequencer

Interface
REQ-001 The block SHALL have parameter ACC_REG, default 2'd0, giving the register-file address of the accumulator.
REQ-002 The block SHALL have parameter CNT_REG, default 2'd1, giving the register-file address of the down-counter; ACC_REG != CNT_REG.
REQ-003 The block SHALL have port clk  input  1  system clock, rising-edge active.
REQ-004 The block SHALL have port restart  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port start  input  1  request to compute Sum = 1+2+...+n, level-sensitive.
REQ-006 The block SHALL have port zflag  input  1  datapath flag, 1 when the shifter output is 8'h00 in the current cycle.
REQ-007 The block SHALL have port IE  output  1  datapath input-mux select, 1 = external n.
REQ-008 The block SHALL have ports WE  output  1 and WA  output  2, register-file write enable and address.
REQ-009 The block SHALL have ports RAE  output  1, RAA  output  2, RBE  output  1 and RBA  output  2, read-port enables and addresses.
REQ-010 The block SHALL have ports ALU  output  3 and SH  output  2, ALU opcode and shifter opcode.
REQ-011 The block SHALL have ports OE  output  1, busy  output  1 and done  output  1: datapath output-buffer enable, operation in progress, result valid.

Function
REQ-012 ALU encoding: 000 pass A, 100 A+B, 101 A-B, 111 A-1; SH encoding: 00 pass; this block SHALL use only these codes.
REQ-013 The FSM SHALL have states IDLE, LOADN, CLR, CHK, ADD, DEC and DONE, registered on the clk rising edge, with Moore outputs.
REQ-014 IDLE: all outputs 0; go to LOADN when start=1, else stay.
REQ-015 LOADN: IE=1, WE=1, WA=CNT_REG, busy=1; next state CLR.
REQ-016 CLR: WE=1, WA=ACC_REG, RAE=RBE=1, RAA=RBA=CNT_REG, ALU=101, busy=1, writing 0 to the accumulator; next state CHK.
REQ-017 CHK: RAE=1, RAA=CNT_REG, ALU=000, WE=0, busy=1; next state DONE if zflag=1, else ADD.
REQ-018 ADD: WE=1, WA=ACC_REG, RAE=RBE=1, RAA=ACC_REG, RBA=CNT_REG, ALU=100, busy=1; next state DEC.
REQ-019 DEC: WE=1, WA=CNT_REG, RAE=1, RAA=CNT_REG, ALU=111, busy=1; next state CHK.
REQ-020 DONE: RAE=1, RAA=ACC_REG, ALU=000, OE=1, done=1, WE=0, busy=0; stay while start=1, go to IDLE when start=0.
REQ-021 Unused control fields SHALL be 0 in every state; SH SHALL be 00 in every state.
REQ-022 Latency: with start sampled at edge E, done SHALL rise after edge E+3+3n and stay high until the edge after start falls.
REQ-023 The arithmetic SHALL be 8-bit modulo 256; overflow SHALL be neither flagged nor saturated.
REQ-024 A start pulse that is high for only one cycle SHALL still complete the operation, and done SHALL then remain high for one cycle.
REQ-025 A start held high through DONE SHALL NOT retrigger; a new operation SHALL require start low for at least one cycle.
REQ-026 Unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-027 restart=1 SHALL immediately force state IDLE and all outputs 0, independent of clk, including mid-operation.
REQ-028 After restart falls, the block SHALL wait in IDLE for start; register-file contents need not be cleared.

Verification
REQ-029 n=0, start pulsed -> LOADN, CLR, CHK, DONE; done=1 after 3 edges; datapath Sum=0.
REQ-030 n=5, start held -> done after 18 edges; Sum=15 (8'h0F); WE never asserted in CHK or DONE.
REQ-031 n=23 -> Sum=276 mod 256=20 (8'h14); n=255 -> Sum=8'h80; done after 768 edges.
REQ-032 restart asserted between clk edges during ADD with n=10 -> all outputs 0 immediately; new start with n=3 -> Sum=6.
REQ-033 Start held high 5 cycles past done -> stays in DONE with OE=1, no retrigger; start low -> IDLE next edge.
REQ-034 Per-state check of the full control word {IE,WE,WA,RAE,RAA,RBE,RBA,ALU,SH,OE} against REQ-014..REQ-020, including non-default ACC_REG=3 and CNT_REG=2.
